// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_queue
// Purpose  : Merges the non-stallable ALU result path and the long-latency
//            load/multiply path (valid/ready, queued in a small FIFO) into the
//            register file's single registered write port. Also reports the
//            pending-write busy flags that decode uses to stall.
// Optional : WBQ_STARVE_GUARD_EN enables a starvation guard that forces a
//            FIFO pop after STARVE_LIMIT starved cycles.
// Revision : 1.0 - initial release
// ============================================================================
module wb_write_queue #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDRESS_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_wd,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_wd,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic                     WE3,
  output logic [DATA_WIDTH-1:0]    WD3,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic                     stall_req,
  output logic                     empty
);

  localparam int c_pw = $clog2(DEPTH);

  logic [c_pw:0]             r_wptr;
  logic [c_pw:0]             r_rptr;
  logic [DEPTH-1:0]          r_live;
  logic [ADDRESS_WIDTH-1:0]  r_rd [DEPTH];
  logic [DATA_WIDTH-1:0]     r_wd [DEPTH];

  logic                      r_we3;
  logic [ADDRESS_WIDTH-1:0]  r_ad3;
  logic [DATA_WIDTH-1:0]     r_wd3;

  logic [c_pw-1:0]           w_widx;
  logic [c_pw-1:0]           w_ridx;
  logic                      w_full;
  logic                      w_occupied;
  logic                      w_head_live;
  logic                      w_force;
  logic                      w_alu_win;
  logic                      w_push;
  logic                      w_enq;
  logic                      w_pop;
  logic                      w_same_edge_kill;
  logic [DEPTH-1:0]          w_kill;
  logic                      w_hit1;
  logic                      w_hit2;

  assign w_widx      = r_wptr[c_pw-1:0];
  assign w_ridx      = r_rptr[c_pw-1:0];
  assign w_full      = (r_wptr[c_pw] != r_rptr[c_pw]) && (w_widx == w_ridx);
  assign w_occupied  = (r_wptr != r_rptr);
  assign w_head_live = w_occupied && r_live[w_ridx];

  assign mem_ready   = !w_full && !rst;
  assign w_push      = mem_valid && mem_ready;
  assign w_enq       = w_push && (mem_rd != '0);

  // The ALU result is younger than a concurrent mem result, so it kills it.
  assign w_alu_win        = alu_valid && (alu_rd != '0) && !w_force;
  assign w_same_edge_kill = w_alu_win && (alu_rd == mem_rd);
  assign w_pop            = w_occupied && !w_alu_win;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
    assign w_kill[gi] = w_alu_win && (r_rd[gi] == alu_rd);
  end

  // Live bits are cleared on pop so unoccupied slots never look pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_live <= '0;
    end else begin
      r_live <= r_live & ~w_kill;
      if (w_pop) begin
        r_live[w_ridx] <= 1'b0;
        r_rptr         <= r_rptr + 1'b1;
      end
      if (w_enq) begin
        r_live[w_widx] <= !w_same_edge_kill;
        r_wptr         <= r_wptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_rd[w_widx] <= mem_rd;
      r_wd[w_widx] <= mem_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we3 <= 1'b0;
      r_ad3 <= '0;
      r_wd3 <= '0;
    end else if (w_alu_win) begin
      r_we3 <= 1'b1;
      r_ad3 <= alu_rd;
      r_wd3 <= alu_wd;
    end else if (w_pop && r_live[w_ridx]) begin
      r_we3 <= 1'b1;
      r_ad3 <= r_rd[w_ridx];
      r_wd3 <= r_wd[w_ridx];
    end else begin
      r_we3 <= 1'b0;
    end
  end

  assign WE3 = r_we3;
  assign AD3 = r_ad3;
  assign WD3 = r_wd3;

  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i] && (r_rd[i] == rs1)) w_hit1 = 1'b1;
      if (r_live[i] && (r_rd[i] == rs2)) w_hit2 = 1'b1;
    end
  end

  // No write-through in the register file: the output register still counts.
  assign rs1_busy = (rs1 != '0) && (w_hit1 || (r_we3 && (r_ad3 == rs1)));
  assign rs2_busy = (rs2 != '0) && (w_hit2 || (r_we3 && (r_ad3 == rs2)));
  assign empty    = ~|r_live;

`ifdef WBQ_STARVE_GUARD_EN
  localparam int c_cw = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_cw-1:0] c_limit = c_cw'(STARVE_LIMIT);

  logic [c_cw-1:0] r_starve;
  logic            r_stall;
  logic            r_force;

  // stall_req warns decode one cycle ahead; the following cycle pops by force.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
      r_force  <= 1'b0;
    end else begin
      r_stall <= 1'b0;
      r_force <= r_stall && !w_pop;
      if (w_pop || empty) begin
        r_starve <= '0;
      end else if (w_head_live && w_alu_win && (r_starve != c_limit)) begin
        r_starve <= r_starve + 1'b1;
        if (r_starve == c_limit - 1'b1) r_stall <= 1'b1;
      end
    end
  end

  assign w_force   = r_force;
  assign stall_req = r_stall;
`else
  logic w_unused_starve_limit;

  assign w_unused_starve_limit = (STARVE_LIMIT > 0);
  assign w_force               = 1'b0;
  assign stall_req             = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_write_queue
// Purpose  : Directed scoreboard bench for wb_write_queue (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_write_queue;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_wd;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_wd;
  logic [AW-1:0] AD3;
  logic          WE3;
  logic [DW-1:0] WD3;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic          rs1_busy;
  logic          rs2_busy;
  logic          stall_req;
  logic          empty;

  int total = 0;
  int bad   = 0;
  logic [AW+DW-1:0] sb[$];

  wb_write_queue #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .DEPTH        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_valid(alu_valid),
    .alu_rd   (alu_rd),
    .alu_wd   (alu_wd),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_rd   (mem_rd),
    .mem_wd   (mem_wd),
    .AD3      (AD3),
    .WE3      (WE3),
    .WD3      (WD3),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .stall_req(stall_req),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] wd);
    alu_valid = v;
    alu_rd    = rd;
    alu_wd    = wd;
    if (v && rd != '0) sb.push_back({rd, wd});
  endtask

  // Every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && WE3) begin
      if (sb.size() == 0) begin
        check("write_unexpected", 64'({AD3, WD3}), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("wb_write", 64'({AD3, WD3}), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stall_at;
    int nstall;
    logic s;
    logic s_prev;

    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_wd = 32'h55;
    rs1 = '0; rs2 = '0;

    // Reset held two cycles with a mem offer pending.
    step();
    step();
    check("rst_mem_ready", 64'(mem_ready), 64'd0);
    check("rst_we3", 64'(WE3), 64'd0);
    check("rst_ad3", 64'(AD3), 64'd0);
    check("rst_wd3", 64'(WD3), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_stall", 64'(stall_req), 64'd0);
    rst = 1'b0;
    mem_valid = 1'b0;
    #1;
    check("post_rst_ready", 64'(mem_ready), 64'd1);

    // ALU path and x0 filtering.
    step();
    drive_alu(1'b1, 5'd5, 32'h1234);
    step();
    check("alu_we3", 64'(WE3), 64'd1);
    check("alu_ad3", 64'(AD3), 64'd5);
    check("alu_wd3", 64'(WD3), 64'h1234);
    drive_alu(1'b1, 5'd0, 32'h777);
    rs1 = 5'd5; rs2 = 5'd6;
    #1;
    check("busy_inflight", 64'(rs1_busy), 64'd1);
    check("busy_other", 64'(rs2_busy), 64'd0);
    step();
    check("x0_alu_no_we", 64'(WE3), 64'd0);
    check("busy_cleared", 64'(rs1_busy), 64'd0);
    drive_alu(1'b0, 5'd0, 32'h0);

    // Fill to full behind a busy ALU stream, drain in order; 3 rounds wrap.
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 4; j++) begin
        drive_alu(1'b1, 5'(16 + j), 32'hC000 + 32'(r * 16 + j));
        mem_valid = 1'b1;
        mem_rd    = 5'(j + 1);
        mem_wd    = 32'hA1 + 32'(j);
        #1;
        check("fill_ready", 64'(mem_ready), 64'd1);
        step();
      end
      mem_valid = 1'b0;
      drive_alu(1'b1, 5'd20, 32'hC0FF + 32'(r));
      rs1 = 5'd3;
      #1;
      check("full_ready_low", 64'(mem_ready), 64'd0);
      check("full_not_empty", 64'(empty), 64'd0);
      check("busy_fifo", 64'(rs1_busy), 64'd1);
      step();
      drive_alu(1'b0, 5'd0, 32'h0);
      for (int j = 0; j < 4; j++) sb.push_back({5'(j + 1), 32'hA1 + 32'(j)});
      repeat (6) step();
      check("drain_empty", 64'(empty), 64'd1);
      check("drain_sb", 64'(sb.size()), 64'd0);
      check("drain_ready", 64'(mem_ready), 64'd1);
    end

    // Kill: queued rd=7 overwritten by a younger ALU write to rd=7.
    drive_alu(1'b1, 5'd10, 32'h10);
    mem_valid = 1'b1; mem_rd = 5'd7; mem_wd = 32'hDEAD;
    step();
    mem_valid = 1'b0;
    drive_alu(1'b1, 5'd11, 32'h11);
    rs1 = 5'd7;
    #1;
    check("kill_busy_queued", 64'(rs1_busy), 64'd1);
    step();
    drive_alu(1'b1, 5'd7, 32'hBEEF);
    step();
    drive_alu(1'b0, 5'd0, 32'h0);
    #1;
    check("kill_busy_inflight", 64'(rs1_busy), 64'd1);
    check("kill_empty", 64'(empty), 64'd1);
    step();
    check("kill_no_we", 64'(WE3), 64'd0);
    check("kill_busy_clear", 64'(rs1_busy), 64'd0);
    step();
    check("kill_sb", 64'(sb.size()), 64'd0);

    // Same-edge kill.
    drive_alu(1'b1, 5'd9, 32'hAAAA);
    mem_valid = 1'b1; mem_rd = 5'd9; mem_wd = 32'h9999;
    step();
    mem_valid = 1'b0;
    drive_alu(1'b0, 5'd0, 32'h0);
    rs2 = 5'd9;
    #1;
    check("same_kill_empty", 64'(empty), 64'd1);
    step();
    check("same_kill_no_we", 64'(WE3), 64'd0);
    check("same_kill_busy", 64'(rs2_busy), 64'd0);
    step();
    check("same_kill_sb", 64'(sb.size()), 64'd0);

    // mem latency: transfer at edge t, write visible after edge t+1.
    mem_valid = 1'b1; mem_rd = 5'd12; mem_wd = 32'h4242;
    sb.push_back({5'd12, 32'h4242});
    step();
    mem_valid = 1'b0;
    check("mem_lat_t", 64'(WE3), 64'd0);
    step();
    check("mem_lat_we", 64'(WE3), 64'd1);
    check("mem_lat_ad", 64'(AD3), 64'd12);
    mem_valid = 1'b1; mem_rd = 5'd0; mem_wd = 32'h1;
    #1;
    check("mem_x0_ready", 64'(mem_ready), 64'd1);
    step();
    mem_valid = 1'b0;
    check("mem_x0_empty", 64'(empty), 64'd1);
    step();
    check("mem_x0_no_we", 64'(WE3), 64'd0);

    // Starvation: one queued entry behind a continuous ALU stream.
    mem_valid = 1'b1; mem_rd = 5'd13; mem_wd = 32'h5151;
    drive_alu(1'b1, 5'd14, 32'hE000);
    step();
    mem_valid = 1'b0;
`ifdef WBQ_STARVE_GUARD_EN
    stall_at = -1;
    nstall   = 0;
    s_prev   = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      s = stall_req;
      if (s) nstall++;
      if (s && stall_at < 0) stall_at = k;
      if (s_prev) begin
        alu_valid = 1'b0;
        sb.push_back({5'd13, 32'h5151});
      end else begin
        drive_alu(1'b1, 5'd14, 32'hE000 + 32'(k));
      end
      s_prev = s;
      step();
    end
    check("starve_stall_cycle", 64'(stall_at), 64'd9);
    check("starve_stall_pulses", 64'(nstall), 64'd1);
`else
    stall_at = 0;
    nstall   = 0;
    s_prev   = 1'b0;
    s        = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      check("stall_tied_low", 64'(stall_req), 64'd0);
      drive_alu(1'b1, 5'd14, 32'hE000 + 32'(k));
      step();
    end
    check("starve_still_queued", 64'(empty), 64'd0);
    alu_valid = 1'b0;
    sb.push_back({5'd13, 32'h5151});
`endif
    drive_alu(1'b0, 5'd0, 32'h0);
    repeat (4) step();
    check("final_empty", 64'(empty), 64'd1);
    check("final_sb", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
